mc_sequencer: RTL and testbench

- Multi-cycle control sequencer for the CPU datapath built around the instruction-decode stage (register file, immediate extender, branch/jump target adders).
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Generates the per-cycle write strobes (IR load, PC write, register write, memory write) and the next-PC select.
- Holds in FETCH and MEM until the shared instruction/data memory returns ready.
- Counts retired instructions and traps on an illegal opcode.

---
 rtl/mc_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_mc_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control sequencer for the decode-centred CPU datapath.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It generates the
// per-cycle write strobes and the next-PC select. It stalls on the shared memory's
// ready signal, counts retired instructions, and traps on an illegal opcode.
//
// Ports:
//   clk       - clock, rising edge
//   clr       - synchronous active-high reset; forces every strobe low while high
//   op        - opcode field of the latched IR
//   rsrtequ   - register-file compare result (qa == qb)
//   mem_ready - shared memory access completes this cycle
//   mem_req   - memory access request
//   mem_we    - memory write strobe (valid with mem_req)
//   addr_sel  - memory address select: 0 = PC, 1 = ALU result
//   ir_we     - instruction register load
//   pc_we     - PC register write
//   pcsource  - next-PC select: 00 = pc4, 01 = bpc, 11 = jpc
//   reg_we    - register-file write enable
//   state     - current state code
//   trap      - sticky illegal-opcode flag
//   instret   - retired-instruction count, wraps silently
//
// state  | meaning
// FETCH  | read instruction at PC, wait for mem_ready, load IR and PC <= pc4
// DECODE | resolve J/BEQ/BNE (retire here), dispatch others, trap illegal op
// EXEC   | ALU cycle, no strobes
// MEM    | data access at ALU address, wait for mem_ready; SW retires here
// WB     | one-cycle register write, retire
// TRAP   | absorbing after an illegal opcode; only clr leaves
module mc_sequencer #(
    parameter int         CNT_W   = 32,
    parameter logic [5:0] OP_R    = 6'b000000,
    parameter logic [5:0] OP_ADDI = 6'b000001,
    parameter logic [5:0] OP_LW   = 6'b000010,
    parameter logic [5:0] OP_SW   = 6'b000011,
    parameter logic [5:0] OP_BEQ  = 6'b000100,
    parameter logic [5:0] OP_BNE  = 6'b000101,
    parameter logic [5:0] OP_J    = 6'b000110
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [5:0]       op,
    input  logic             rsrtequ,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pcsource,
    output logic             reg_we,
    output logic [2:0]       state,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_RSV5   = 3'd5,
        S_RSV6   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    state_t state_q;
    state_t state_nxt;
    logic   trap_set;
    logic   retire;
    logic   br_taken;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_FETCH;
            trap    <= 1'b0;
            instret <= '0;
        end else begin
            state_q <= state_nxt;
            if (trap_set) begin
                trap <= 1'b1;
            end
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pcsource  = 2'b00;
        reg_we    = 1'b0;
        trap_set  = 1'b0;
        retire    = 1'b0;
        br_taken  = (op == OP_BEQ) ? rsrtequ : !rsrtequ;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_J: begin
                        pc_we     = 1'b1;
                        pcsource  = 2'b11;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    OP_BEQ, OP_BNE: begin
                        if (br_taken) begin
                            pc_we    = 1'b1;
                            pcsource = 2'b01;
                        end
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    OP_R, OP_ADDI, OP_LW, OP_SW: begin
                        state_nxt = S_EXEC;
                    end
                    default: begin
                        trap_set  = 1'b1;
                        state_nxt = S_TRAP;
                    end
                endcase
            end
            S_EXEC: begin
                state_nxt = (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (op == OP_SW);
                if (mem_ready) begin
                    if (op == OP_SW) begin
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we    = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_TRAP: begin
                state_nxt = S_TRAP;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase

        // Reset abandons the current instruction: nothing may write on the reset edge.
        if (clr) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            addr_sel = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            pcsource = 2'b00;
            reg_we   = 1'b0;
            trap_set = 1'b0;
            retire   = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Testbench for mc_sequencer (4-bit instret build so the counter wrap is reachable).
module tb_mc_sequencer;

    localparam int         CNT_W   = 4;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_LW   = 6'b000010;
    localparam logic [5:0] OP_SW   = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000110;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    // strobe vector order: {mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we}
    localparam logic [5:0] SB_NONE  = 6'b000000;
    localparam logic [5:0] SB_FWAIT = 6'b100000;
    localparam logic [5:0] SB_FRDY  = 6'b100110;
    localparam logic [5:0] SB_PC    = 6'b000010;
    localparam logic [5:0] SB_LDMEM = 6'b101000;
    localparam logic [5:0] SB_STMEM = 6'b111000;
    localparam logic [5:0] SB_WB    = 6'b000001;

    logic             clk;
    logic             clr;
    logic [5:0]       op;
    logic             rsrtequ;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             addr_sel;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pcsource;
    logic             reg_we;
    logic [2:0]       state;
    logic             trap;
    logic [CNT_W-1:0] instret;

    mc_sequencer #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .clr       (clr),
        .op        (op),
        .rsrtequ   (rsrtequ),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pcsource  (pcsource),
        .reg_we    (reg_we),
        .state     (state),
        .trap      (trap),
        .instret   (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic [2:0]       st;
        logic [5:0]       sb;
        logic [1:0]       pcs;
        logic             trp;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             exp_q[$];
    logic [CNT_W-1:0] exp_ins;
    logic             exp_trap;
    int               n_chk;
    int               n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Monitor: sample mid-cycle, compare against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, ".state"},    32'(state),    32'(e.st));
            check({e.tag, ".strobes"},  32'({mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we}), 32'(e.sb));
            check({e.tag, ".pcsource"}, 32'(pcsource), 32'(e.pcs));
            check({e.tag, ".trap"},     32'(trap),     32'(e.trp));
            check({e.tag, ".instret"},  32'(instret),  32'(e.cnt));
            check({e.tag, ".wr_excl"},  32'($countones({ir_we, reg_we, mem_we}) <= 1), 32'd1);
        end
    end

    task automatic step(input string tag, input logic c, input logic [5:0] o, input logic eq,
                        input logic rdy, input logic [2:0] es, input logic [5:0] eb,
                        input logic [1:0] ep, input logic ret);
        exp_t e;
        @(posedge clk);
        #1;
        clr       = c;
        op        = o;
        rsrtequ   = eq;
        mem_ready = rdy;
        e.tag = tag;
        e.st  = es;
        e.sb  = eb;
        e.pcs = ep;
        e.trp = exp_trap;
        e.cnt = exp_ins;
        exp_q.push_back(e);
        if (ret) exp_ins = exp_ins + 1'b1;
        if (c) begin
            exp_ins  = '0;
            exp_trap = 1'b0;
        end
    endtask

    task automatic issue(input string tag, input logic [5:0] o, input logic eq,
                         input int fw, input int mw);
        logic rnd;
        for (int i = 0; i < fw; i++) step({tag, ".fwait"}, 1'b0, o, eq, 1'b0, 3'd0, SB_FWAIT, 2'b00, 1'b0);
        step({tag, ".fetch"}, 1'b0, o, eq, 1'b1, 3'd0, SB_FRDY, 2'b00, 1'b0);
        rnd = 1'($urandom_range(0, 1));
        case (o)
            OP_J: step({tag, ".dec"}, 1'b0, o, eq, rnd, 3'd1, SB_PC, 2'b11, 1'b1);
            OP_BEQ, OP_BNE: begin
                if ((o == OP_BEQ && eq) || (o == OP_BNE && !eq))
                    step({tag, ".dec"}, 1'b0, o, eq, rnd, 3'd1, SB_PC, 2'b01, 1'b1);
                else
                    step({tag, ".dec"}, 1'b0, o, eq, rnd, 3'd1, SB_NONE, 2'b00, 1'b1);
            end
            OP_R, OP_ADDI, OP_LW, OP_SW: begin
                step({tag, ".dec"}, 1'b0, o, eq, rnd, 3'd1, SB_NONE, 2'b00, 1'b0);
                step({tag, ".exec"}, 1'b0, o, eq, 1'b1, 3'd2, SB_NONE, 2'b00, 1'b0);
                if (o == OP_LW || o == OP_SW) begin
                    for (int i = 0; i < mw; i++)
                        step({tag, ".mwait"}, 1'b0, o, eq, 1'b0, 3'd3,
                             (o == OP_SW) ? SB_STMEM : SB_LDMEM, 2'b00, 1'b0);
                    step({tag, ".mem"}, 1'b0, o, eq, 1'b1, 3'd3,
                         (o == OP_SW) ? SB_STMEM : SB_LDMEM, 2'b00, (o == OP_SW));
                end
                if (o != OP_SW)
                    step({tag, ".wb"}, 1'b0, o, eq, rnd, 3'd4, SB_WB, 2'b00, 1'b1);
            end
            default: begin
                step({tag, ".dec"}, 1'b0, o, eq, 1'b1, 3'd1, SB_NONE, 2'b00, 1'b0);
                exp_trap = 1'b1;
            end
        endcase
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        exp_ins   = '0;
        exp_trap  = 1'b0;
        clr       = 1'b1;
        op        = OP_R;
        rsrtequ   = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        step("reset", 1'b1, OP_R, 1'b0, 1'b1, 3'd0, SB_NONE, 2'b00, 1'b0);

        issue("addi", OP_ADDI, 1'b0, 0, 0);
        issue("lw", OP_LW, 1'b1, 0, 3);
        issue("beq_t", OP_BEQ, 1'b1, 0, 0);
        issue("bne_nt", OP_BNE, 1'b1, 0, 0);
        issue("beq_nt", OP_BEQ, 1'b0, 1, 0);
        issue("bne_t", OP_BNE, 1'b0, 0, 0);
        issue("j", OP_J, 1'b0, 0, 0);
        issue("sw", OP_SW, 1'b1, 0, 2);
        issue("r", OP_R, 1'b1, 2, 0);
        issue("lw0", OP_LW, 1'b0, 0, 0);

        issue("bad", OP_BAD, 1'b0, 0, 0);
        for (int i = 0; i < 10; i++)
            step("trap", 1'b0, OP_BAD, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'd7, SB_NONE, 2'b00, 1'b0);
        step("trap_clr", 1'b1, OP_BAD, 1'b0, 1'b1, 3'd7, SB_NONE, 2'b00, 1'b0);
        issue("post_trap_addi", OP_ADDI, 1'b0, 0, 0);

        step("reset2", 1'b1, OP_J, 1'b0, 1'b1, 3'd0, SB_NONE, 2'b00, 1'b0);
        for (int i = 0; i < 15; i++) issue("fill", OP_J, 1'b0, 0, 0);
        issue("wrap", OP_J, 1'b0, 0, 0);

        step("sw_abort.fetch", 1'b0, OP_SW, 1'b0, 1'b1, 3'd0, SB_FRDY, 2'b00, 1'b0);
        step("sw_abort.dec", 1'b0, OP_SW, 1'b0, 1'b1, 3'd1, SB_NONE, 2'b00, 1'b0);
        step("sw_abort.exec", 1'b0, OP_SW, 1'b0, 1'b1, 3'd2, SB_NONE, 2'b00, 1'b0);
        step("sw_abort.mwait", 1'b0, OP_SW, 1'b0, 1'b0, 3'd3, SB_STMEM, 2'b00, 1'b0);
        step("sw_abort.clr", 1'b1, OP_SW, 1'b0, 1'b1, 3'd3, SB_NONE, 2'b00, 1'b0);
        step("sw_abort.after", 1'b0, OP_SW, 1'b0, 1'b0, 3'd0, SB_FWAIT, 2'b00, 1'b0);
        step("sw_abort.after2", 1'b0, OP_SW, 1'b0, 1'b0, 3'd0, SB_FWAIT, 2'b00, 1'b0);

        @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
